cmac_bringup_ctrl: RTL and testbench

CMAC_BRINGUP_CTRL -- requirements
Module: cmac_bringup_ctrl

---
 rtl/cmac_bringup_ctrl.sv | 164 ++++++++++++++++
 tb/tb_cmac_bringup_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmac_bringup_ctrl.sv
// CMAC link bring-up sequencer: RX alignment, timeout-driven resync, TX enable
// and link monitoring with saturating event counters and a sticky TX error flag.
module cmac_bringup_ctrl #(
    parameter int ALIGN_TIMEOUT = 1000000,
    parameter int STABLE_CYCLES = 256,
    parameter int RESYNC_CYCLES = 16
) (
    input  logic        cmac_rxtx_clk,
    input  logic        cmac_reset,
    input  logic        enable,
    input  logic        clear,
    input  logic        stat_rx_aligned,
    input  logic        tx_ovfout,
    input  logic        tx_unfout,
    output logic        ctl_rx_enable,
    output logic        ctl_rx_force_resync,
    output logic        ctl_tx_enable,
    output logic        ctl_tx_send_lfi,
    output logic        ctl_tx_send_rfi,
    output logic        ctl_tx_send_idle,
    output logic        link_up,
    output logic [2:0]  state,
    output logic [7:0]  resync_cnt,
    output logic [15:0] link_drop_cnt,
    output logic        tx_err
);

    // state    | meaning
    // IDLE     | link not requested, all CMAC controls low
    // RX_INIT  | RX enabled, sending LFI/RFI, waiting for stable alignment
    // RESYNC   | force-resync pulse to the RX, sending idle/RFI
    // TX_INIT  | TX enabled, one-cycle alignment re-check
    // LINK_UP  | link running, monitoring alignment and TX strobes
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RX_INIT = 3'd1,
        ST_RESYNC  = 3'd2,
        ST_TX_INIT = 3'd3,
        ST_LINK_UP = 3'd4
    } state_t;

    localparam int TMR_MAX = (ALIGN_TIMEOUT > RESYNC_CYCLES) ? ALIGN_TIMEOUT : RESYNC_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int STB_W   = $clog2(STABLE_CYCLES + 1);

    localparam logic [TMR_W-1:0] TIMEOUT_TC = TMR_W'(ALIGN_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] RESYNC_TC  = TMR_W'(RESYNC_CYCLES - 1);
    localparam logic [STB_W-1:0] STABLE_TC  = STB_W'(STABLE_CYCLES - 1);

    state_t             st_q, st_nxt;
    logic [TMR_W-1:0]   tmr_q, tmr_nxt;
    logic [STB_W-1:0]   stb_q, stb_nxt;
    logic               resync_inc, drop_inc, err_set;
    logic [5:0]         ctl_nxt;

    always_comb begin
        st_nxt     = st_q;
        tmr_nxt    = '0;
        stb_nxt    = '0;
        resync_inc = 1'b0;
        drop_inc   = 1'b0;
        case (st_q)
            ST_IDLE: begin
                if (enable) st_nxt = ST_RX_INIT;
            end
            ST_RX_INIT: begin
                tmr_nxt = tmr_q + 1'b1;
                stb_nxt = stat_rx_aligned ? stb_q + 1'b1 : '0;
                // stable alignment beats a coincident timeout
                if (stat_rx_aligned && (stb_q == STABLE_TC)) begin
                    st_nxt = ST_TX_INIT;
                end else if (tmr_q == TIMEOUT_TC) begin
                    st_nxt     = ST_RESYNC;
                    resync_inc = 1'b1;
                end
            end
            ST_RESYNC: begin
                tmr_nxt = tmr_q + 1'b1;
                if (tmr_q == RESYNC_TC) st_nxt = ST_RX_INIT;
            end
            ST_TX_INIT: begin
                st_nxt = stat_rx_aligned ? ST_LINK_UP : ST_RX_INIT;
            end
            ST_LINK_UP: begin
                if (!stat_rx_aligned) begin
                    st_nxt   = ST_RX_INIT;
                    drop_inc = 1'b1;
                end
            end
            default: st_nxt = ST_IDLE;
        endcase

        if (!enable) begin
            st_nxt     = ST_IDLE;
            resync_inc = 1'b0;
            drop_inc   = 1'b0;
        end

        // timers restart on every state change so none can run past its terminal count
        if (st_nxt != st_q) begin
            tmr_nxt = '0;
            stb_nxt = '0;
        end
    end

    assign err_set = (st_q == ST_LINK_UP) && (tx_ovfout || tx_unfout);

    // {rx_enable, force_resync, tx_enable, send_lfi, send_rfi, send_idle}
    always_comb begin
        ctl_nxt = 6'b000000;
        case (st_nxt)
            ST_RX_INIT: ctl_nxt = 6'b100110;
            ST_RESYNC:  ctl_nxt = 6'b110011;
            ST_TX_INIT: ctl_nxt = 6'b101000;
            ST_LINK_UP: ctl_nxt = 6'b101000;
            default:    ctl_nxt = 6'b000000;
        endcase
    end

    always_ff @(posedge cmac_rxtx_clk or negedge cmac_reset) begin
        if (!cmac_reset) begin
            st_q                <= ST_IDLE;
            tmr_q               <= '0;
            stb_q               <= '0;
            ctl_rx_enable       <= 1'b0;
            ctl_rx_force_resync <= 1'b0;
            ctl_tx_enable       <= 1'b0;
            ctl_tx_send_lfi     <= 1'b0;
            ctl_tx_send_rfi     <= 1'b0;
            ctl_tx_send_idle    <= 1'b0;
            link_up             <= 1'b0;
            resync_cnt          <= '0;
            link_drop_cnt       <= '0;
            tx_err              <= 1'b0;
        end else begin
            st_q                <= st_nxt;
            tmr_q               <= tmr_nxt;
            stb_q               <= stb_nxt;
            ctl_rx_enable       <= ctl_nxt[5];
            ctl_rx_force_resync <= ctl_nxt[4];
            ctl_tx_enable       <= ctl_nxt[3];
            ctl_tx_send_lfi     <= ctl_nxt[2];
            ctl_tx_send_rfi     <= ctl_nxt[1];
            ctl_tx_send_idle    <= ctl_nxt[0];
            link_up             <= (st_nxt == ST_LINK_UP);

            if (clear) begin
                resync_cnt    <= '0;
                link_drop_cnt <= '0;
                tx_err        <= 1'b0;
            end else begin
                if (resync_inc && (resync_cnt != 8'hFF))
                    resync_cnt <= resync_cnt + 8'd1;
                if (drop_inc && (link_drop_cnt != 16'hFFFF))
                    link_drop_cnt <= link_drop_cnt + 16'd1;
                if (err_set)
                    tx_err <= 1'b1;
            end
        end
    end

    assign state = st_q;

endmodule

// File: tb/tb_cmac_bringup_ctrl.sv
// Bench for cmac_bringup_ctrl: directed bring-up scenarios plus random traffic,
// checked every cycle against a cycle-counting model of the link rules.
module tb_cmac_bringup_ctrl;

    localparam int STABLE  = 4;
    localparam int TIMEOUT = 16;
    localparam int RESYNC  = 3;

    logic        clk;
    logic        cmac_reset;
    logic        enable, clear, stat_rx_aligned, tx_ovfout, tx_unfout;
    logic        ctl_rx_enable, ctl_rx_force_resync, ctl_tx_enable;
    logic        ctl_tx_send_lfi, ctl_tx_send_rfi, ctl_tx_send_idle;
    logic        link_up;
    logic [2:0]  state;
    logic [7:0]  resync_cnt;
    logic [15:0] link_drop_cnt;
    logic        tx_err;

    int n_vec = 0;
    int n_mis = 0;

    // model: current state number, edges spent in it, current aligned run, counters
    int m_st, m_dwell, m_run, m_rs, m_ld;
    bit m_err;

    cmac_bringup_ctrl #(
        .ALIGN_TIMEOUT(TIMEOUT),
        .STABLE_CYCLES(STABLE),
        .RESYNC_CYCLES(RESYNC)
    ) dut (
        .cmac_rxtx_clk       (clk),
        .cmac_reset          (cmac_reset),
        .enable              (enable),
        .clear               (clear),
        .stat_rx_aligned     (stat_rx_aligned),
        .tx_ovfout           (tx_ovfout),
        .tx_unfout           (tx_unfout),
        .ctl_rx_enable       (ctl_rx_enable),
        .ctl_rx_force_resync (ctl_rx_force_resync),
        .ctl_tx_enable       (ctl_tx_enable),
        .ctl_tx_send_lfi     (ctl_tx_send_lfi),
        .ctl_tx_send_rfi     (ctl_tx_send_rfi),
        .ctl_tx_send_idle    (ctl_tx_send_idle),
        .link_up             (link_up),
        .state               (state),
        .resync_cnt          (resync_cnt),
        .link_drop_cnt       (link_drop_cnt),
        .tx_err              (tx_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // expected {rx_enable, force_resync, tx_enable, send_lfi, send_rfi, send_idle}
    function automatic logic [5:0] ctl_of(input int s);
        case (s)
            1:       return 6'b100110;
            2:       return 6'b110011;
            3, 4:    return 6'b101000;
            default: return 6'b000000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_dwell = 0; m_run = 0; m_rs = 0; m_ld = 0; m_err = 0;
    endtask

    task automatic model_edge();
        int ns, run_nx;
        bit rs_inc, ld_inc;
        ns = m_st; run_nx = 0; rs_inc = 0; ld_inc = 0;
        case (m_st)
            0: if (enable) ns = 1;
            1: begin
                run_nx = stat_rx_aligned ? m_run + 1 : 0;
                if (run_nx == STABLE) ns = 3;
                else if (m_dwell + 1 == TIMEOUT) begin ns = 2; rs_inc = 1; end
            end
            2: if (m_dwell + 1 == RESYNC) ns = 1;
            3: ns = stat_rx_aligned ? 4 : 1;
            4: if (!stat_rx_aligned) begin ns = 1; ld_inc = 1; end
            default: ns = 0;
        endcase
        if (!enable) begin ns = 0; rs_inc = 0; ld_inc = 0; end
        if (clear) begin
            m_rs = 0; m_ld = 0; m_err = 0;
        end else begin
            if (rs_inc && m_rs < 255) m_rs++;
            if (ld_inc && m_ld < 65535) m_ld++;
            if (m_st == 4 && (tx_ovfout || tx_unfout)) m_err = 1;
        end
        if (ns != m_st) begin m_dwell = 0; m_run = 0; end
        else begin m_dwell++; m_run = run_nx; end
        m_st = ns;
    endtask

    task automatic check_all();
        chk("state", state, m_st);
        chk("ctl", {ctl_rx_enable, ctl_rx_force_resync, ctl_tx_enable,
                    ctl_tx_send_lfi, ctl_tx_send_rfi, ctl_tx_send_idle}, ctl_of(m_st));
        chk("link_up", link_up, (m_st == 4));
        chk("resync_cnt", resync_cnt, m_rs);
        chk("link_drop_cnt", link_drop_cnt, m_ld);
        chk("tx_err", tx_err, m_err);
    endtask

    task automatic set_in(input bit en, input bit al, input bit clr, input bit ovf, input bit unf);
        enable = en; stat_rx_aligned = al; clear = clr; tx_ovfout = ovf; tx_unfout = unf;
    endtask

    task automatic step();
        @(posedge clk);
        if (cmac_reset) model_edge();
        else model_reset();
        #1;
        check_all();
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {ctl_rx_enable, ctl_rx_force_resync, ctl_tx_enable, ctl_tx_send_lfi,
                  ctl_tx_send_rfi, ctl_tx_send_idle, link_up, state, resync_cnt,
                  link_drop_cnt, tx_err}, 64'd0);
    endtask

    initial begin
        int seg, mode;
        cmac_reset = 1'b0;
        set_in(0, 0, 0, 0, 0);
        model_reset();
        #12;
        chk_all_zero("reset_outs");
        cmac_reset = 1'b1;

        // nominal bring-up, aligned from edge 3
        set_in(1, 0, 0, 0, 0); step();
        chk("nom_e1_state", state, 1);
        step();
        stat_rx_aligned = 1'b1;
        step(); step(); step();
        chk("nom_e5_state", state, 1);
        step();
        chk("nom_e6_state", state, 3);
        chk("nom_e6_lfi", ctl_tx_send_lfi, 0);
        step();
        chk("nom_e7_link_up", link_up, 1);

        // underflow in LINK_UP sets tx_err, clear removes it
        set_in(1, 1, 0, 0, 1); step();
        chk("unf_err", tx_err, 1);
        set_in(1, 1, 1, 0, 0); step();
        chk("clear_err", tx_err, 0);

        // drop from LINK_UP
        set_in(1, 0, 0, 0, 0); step();
        chk("drop_state", state, 1);
        chk("drop_cnt", link_drop_cnt, 1);
        chk("drop_rfi", ctl_tx_send_rfi, 1);

        // glitched alignment 1,1,1,0,1,1,1,1
        for (int i = 0; i < 8; i++) begin
            stat_rx_aligned = (i != 3);
            step();
            if (i == 6) chk("glitch_e7_state", state, 1);
        end
        chk("glitch_e8_state", state, 3);
        stat_rx_aligned = 1'b1; step();
        chk("glitch_linkup", state, 4);

        // second drop, then overflow in RX_INIT must not set tx_err, then timeout
        set_in(1, 0, 0, 0, 0); step();
        chk("drop2_cnt", link_drop_cnt, 2);
        for (int k = 1; k <= 15; k++) begin
            set_in(1, 0, 0, (k == 1), 0);
            step();
            if (k == 1) chk("ovf_rxinit_err", tx_err, 0);
        end
        chk("to_e15_state", state, 1);
        step();
        chk("to_e16_state", state, 2);
        chk("to_resync_cnt", resync_cnt, 1);
        chk("to_force_0", ctl_rx_force_resync, 1);
        step(); chk("to_force_1", ctl_rx_force_resync, 1);
        step(); chk("to_force_2", ctl_rx_force_resync, 1);
        step();
        chk("to_force_end", ctl_rx_force_resync, 0);
        chk("to_back_rxinit", state, 1);

        // enable=0 during RESYNC
        for (int k = 0; k < 16; k++) step();
        chk("pri_resync_state", state, 2);
        enable = 1'b0; step();
        chk("pri_idle_state", state, 0);
        chk("pri_force", ctl_rx_force_resync, 0);
        chk("pri_resync_cnt", resync_cnt, 2);

        // stable run completes on the timeout edge
        set_in(1, 0, 0, 0, 0); step();
        for (int k = 1; k <= 16; k++) begin
            stat_rx_aligned = (k > 12);
            step();
        end
        chk("coinc_state", state, 3);
        chk("coinc_resync_cnt", resync_cnt, 2);
        stat_rx_aligned = 1'b1; step();

        // clear coincident with a link drop
        set_in(1, 0, 1, 0, 0); step();
        chk("clr_drop_cnt", link_drop_cnt, 0);
        chk("clr_drop_state", state, 1);

        // 300 timeouts saturate resync_cnt
        set_in(1, 0, 0, 0, 0);
        for (int k = 0; k < 300 * (TIMEOUT + RESYNC); k++) step();
        chk("sat_resync_cnt", resync_cnt, 255);

        // reset asserted mid-RESYNC
        for (int k = 0; k < 16; k++) step();
        chk("sat_hold_cnt", resync_cnt, 255);
        step();
        #2 cmac_reset = 1'b0;
        #1 chk_all_zero("rst_resync");
        model_reset();
        step(); step();
        #3 cmac_reset = 1'b1;
        enable = 1'b0; step();
        chk("rst_rel_idle", state, 0);
        enable = 1'b1; step();
        chk("rst_rel_rxinit", state, 1);

        // random traffic
        seg = 0; mode = 0;
        for (int k = 0; k < 3000; k++) begin
            if (seg == 0) begin
                seg  = $urandom_range(10, 60);
                mode = $urandom_range(0, 2);
            end
            seg--;
            enable          = ($urandom_range(0, 63) != 0);
            stat_rx_aligned = (mode == 0) ? ($urandom_range(0, 7) != 0) :
                              (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            clear           = ($urandom_range(0, 99) == 0);
            tx_ovfout       = ($urandom_range(0, 19) == 0);
            tx_unfout       = ($urandom_range(0, 19) == 0);
            step();
        end

        // reset asserted mid-LINK_UP
        set_in(0, 1, 0, 0, 0); step();
        enable = 1'b1;
        for (int k = 0; k < 6; k++) step();
        chk("pre_rst_linkup", state, 4);
        #2 cmac_reset = 1'b0;
        #1 chk_all_zero("rst_linkup");
        model_reset();
        step();
        #3 cmac_reset = 1'b1;
        enable = 1'b0; step();
        chk("post_rst_idle0", state, 0);
        step();
        chk("post_rst_idle1", state, 0);
        enable = 1'b1; step();
        chk("post_rst_rxinit", state, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
